// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   alu_op_t    - opcode encoding; 12..15 are undefined and report Illegal.
//   alu_state_t - controller states; the multiply state exists only when the
//                 multiplier is built (macro ALU_SEQ_MUL_EN).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpAdc  = 4'd1,
    OpSub  = 4'd2,
    OpAnd  = 4'd3,
    OpXor  = 4'd4,
    OpCpy  = 4'd5,
    OpFlip = 4'd6,
    OpSetb = 4'd7,
    OpGetb = 4'd8,
    OpLshn = 4'd9,
    OpRshn = 4'd10,
    OpMul  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    StShift = 2'd1,
    StMul   = 2'd2
`else
    StShift = 2'd1
`endif
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result bundle between the controller and the ALU.
//   master (controller): drives start, op, a, b, imm, sc_in.
//   slave  (alu_seq)   : drives busy, done, illegal, out, hi, zero, carry, parity.
// Parameters: W data width, Ops opcode width; imm is $clog2(W) bits wide.
interface alu_seq_if #(
  parameter int unsigned W   = 8,
  parameter int unsigned Ops = 4
);
  localparam int unsigned IW = $clog2(W);

  logic           start;
  logic [Ops-1:0] op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [IW-1:0]  imm;
  logic           sc_in;
  logic           busy;
  logic           done;
  logic           illegal;
  logic [W-1:0]   out;
  logic [W-1:0]   hi;
  logic           zero;
  logic           carry;
  logic           parity;

  modport master (
    output start, op, a, b, imm, sc_in,
    input  busy, done, illegal, out, hi, zero, carry, parity
  );

  modport slave (
    input  start, op, a, b, imm, sc_in,
    output busy, done, illegal, out, hi, zero, carry, parity
  );

endinterface

// File: rtl/alu_seq_mul.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial product per step.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - capture a (multiplicand) and b (multiplier), arm W steps
//   step      - perform one iteration
//   a, b      - operands
//   prod      - accumulator value after the current step (valid with done)
//   done      - the current step is the last one
// Built only when ALU_SEQ_MUL_EN is defined.
module alu_mul_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           done
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mcand_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     upper;

  // Multiplier sits in the low half and drains out as the sum shifts in from the top.
  always_comb begin
    upper = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {upper, acc_q[W-1:1]};
  end

  assign prod = acc_d;
  assign done = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      acc_q   <= {{W{1'b0}}, b};
      mcand_q <= a;
      cnt_q   <= CW'(W);
    end else if (step && cnt_q != '0) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential datapath ALU with registered result/flags and start/done handshake.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - alu_seq_if.slave: start/op/a/b/imm/sc_in in; busy/done/illegal/out/hi/flags out
// Single-cycle ops finish on the issue edge; shifts by imm>=2 take imm edges; MUL takes W+1.
// Macro ALU_SEQ_MUL_EN builds the multiplier; without it MUL is illegal and hi reads 0.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned Ops = 4
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int unsigned IW = $clog2(W);

  alu_state_t    state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic          zero_q, zero_d, carry_q, carry_d, parity_q, parity_d;
  logic          done_q, done_d, illegal_q, illegal_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          sc_q, sc_d, left_q, left_d;
  logic          upd_flags;
  logic [W:0]    sum, sh1;
  logic [W-1:0]  bit_mask;
  alu_op_t       op_dec;
  logic          op_hi_zero;

  // Returns {bit shifted out, shifted value}.
  function automatic logic [W:0] shift1(input logic [W-1:0] v, input logic left,
                                        input logic fill);
    return left ? {v, fill} : {v[0], fill, v[W-1:1]};
  endfunction

  assign op_dec     = alu_op_t'(bus.op[3:0]);
  assign op_hi_zero = ((bus.op >> 4) == '0);
  assign bit_mask   = W'(1) << bus.imm;

`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]   hi_q, hi_d;
  logic [2*W-1:0] mul_prod;
  logic           mul_load, mul_step, mul_done;

  alu_mul_seq #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .step (mul_step),
    .a    (bus.a),
    .b    (bus.b),
    .prod (mul_prod),
    .done (mul_done)
  );
`endif

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    sc_d      = sc_q;
    left_d    = left_q;
    upd_flags = 1'b0;
    sum       = '0;
    sh1       = '0;
`ifdef ALU_SEQ_MUL_EN
    hi_d      = hi_q;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          done_d = 1'b1;
          if (!op_hi_zero) begin
            illegal_d = 1'b1;
          end else begin
            unique case (op_dec)
              OpAdd, OpAdc, OpSub: begin
                if (op_dec == OpSub) begin
                  sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1);
                end else begin
                  sum = {1'b0, bus.a} + {1'b0, bus.b} +
                        ((op_dec == OpAdc) ? (W+1)'(carry_q) : '0);
                end
                out_d     = sum[W-1:0];
                carry_d   = sum[W];
                upd_flags = 1'b1;
              end
              OpAnd:  begin out_d = bus.a & bus.b;    upd_flags = 1'b1; end
              OpXor:  begin out_d = bus.a ^ bus.b;    upd_flags = 1'b1; end
              OpCpy:  begin out_d = bus.b;            upd_flags = 1'b1; end
              OpFlip: begin out_d = bus.a ^ bit_mask; upd_flags = 1'b1; end
              OpSetb: begin
                out_d     = bus.sc_in ? (bus.a | bit_mask) : (bus.a & ~bit_mask);
                upd_flags = 1'b1;
              end
              OpGetb: carry_d = bus.a[bus.imm];
              OpLshn, OpRshn: begin
                upd_flags = 1'b1;
                sh1       = shift1(bus.a, op_dec == OpLshn, bus.sc_in);
                if (bus.imm == '0) begin
                  out_d = bus.a;
                end else if (bus.imm == IW'(1)) begin
                  out_d   = sh1[W-1:0];
                  carry_d = sh1[W];
                end else begin
                  // First bit shifts on the issue edge; imm-1 more follow in StShift.
                  upd_flags = 1'b0;
                  done_d    = 1'b0;
                  sh_d      = sh1[W-1:0];
                  cnt_d     = bus.imm - IW'(1);
                  sc_d      = bus.sc_in;
                  left_d    = (op_dec == OpLshn);
                  state_d   = StShift;
                end
              end
`ifdef ALU_SEQ_MUL_EN
              OpMul: begin
                done_d   = 1'b0;
                mul_load = 1'b1;
                state_d  = StMul;
              end
`endif
              default: illegal_d = 1'b1;
            endcase
          end
        end
      end
      StShift: begin
        sh1  = shift1(sh_q, left_q, sc_q);
        sh_d = sh1[W-1:0];
        if (cnt_q == IW'(1)) begin
          out_d     = sh1[W-1:0];
          carry_d   = sh1[W];
          upd_flags = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - IW'(1);
        end
      end
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        mul_step = 1'b1;
        if (mul_done) begin
          out_d     = mul_prod[W-1:0];
          hi_d      = mul_prod[2*W-1:W];
          carry_d   = |mul_prod[2*W-1:W];
          upd_flags = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    if (upd_flags) begin
      zero_d   = ~|out_d;
      parity_d = ^out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      out_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      sh_q      <= '0;
      cnt_q     <= '0;
      sc_q      <= 1'b0;
      left_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      parity_q  <= parity_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      sc_q      <= sc_d;
      left_q    <= left_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end
  assign bus.hi = hi_q;
`else
  assign bus.hi = '0;
`endif

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.out     = out_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.parity  = parity_q;

endmodule
